// File: rtl/pwm.sv
// Fixed-ratio PWM generator: about 50% duty with the extra odd cycle spent high.
// The period is latched at each period start, and the output is registered.
module pwm #(
  parameter int unsigned CLK_PERIOD = 20,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] pwm_period,
  output logic             out
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  // Elaboration-time sanity checks on the parameters.
  if (CLK_PERIOD == 0) begin : g_bad_clk_period
    $error("pwm: CLK_PERIOD must be nonzero");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("pwm: WIDTH must be at least 2");
  end

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             out_q, out_d;

  logic [WIDTH-1:0] high_cur;
  logic [WIDTH-1:0] high_new;
  logic [WIDTH-1:0] cnt_inc;
  logic             wrap;

  // The high time is ceil(P/2). Writing it as P - floor(P/2) keeps it within WIDTH bits.
  assign high_cur = per_q - (per_q >> 1);
  assign high_new = pwm_period - (pwm_period >> 1);

  // The increment is used only when cnt_q < per_q - 1, so it cannot overflow.
  assign cnt_inc  = cnt_q + One;

  // With P == 0, every cycle counts as a period end, so the period input is re-sampled each cycle.
  assign wrap     = (per_q == '0) || (cnt_q == per_q - One);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    out_d   = out_q;

    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      out_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StRun;
          cnt_d   = '0;
          per_d   = pwm_period;
          out_d   = (high_new != '0);
        end
        StRun: begin
          if (wrap) begin
            cnt_d = '0;
            per_d = pwm_period;
            out_d = (high_new != '0);
          end else begin
            cnt_d = cnt_inc;
            out_d = (cnt_inc < high_cur);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          out_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      per_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: run-length vector table, hand sequences, and
// randomized stimulus checked against a queue-based waveform model.
module tb_pwm;

  localparam int unsigned ClkPeriod = 20;
  localparam int unsigned Width     = 8;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [Width-1:0] pwm_period;
  logic             out;

  int unsigned checks;
  int unsigned errors;
  int unsigned cyc;

  // Reference waveform: each period start queues its H ones and P-H zeros.
  bit mq[$];

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  per;
    int unsigned n;
    logic        exp;
    string       name;
  } seg_t;

  seg_t tbl[$];

  pwm #(
    .CLK_PERIOD(ClkPeriod),
    .WIDTH     (Width)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pwm_period(pwm_period),
    .out       (out)
  );

  initial clk = 1'b0;
  always #(ClkPeriod / 2) clk = ~clk;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation exceeded time limit, out=%b", out);
    $fatal(1);
  end

  task automatic step(input logic r, input logic e, input logic [7:0] p, input logic exp,
                      input bit use_model, input string name);
    bit mexp;
    bit want;
    int h;
    @(negedge clk);
    rst        = r;
    enable     = e;
    pwm_period = p;
    @(posedge clk);
    #1;
    cyc++;
    if (r || !e) begin
      mq.delete();
      mexp = 1'b0;
    end else begin
      if (mq.size() == 0) begin
        h = int'(p) - int'(p) / 2;
        if (p == 0) mq.push_back(1'b0);
        else begin
          for (int i = 0; i < h; i++) mq.push_back(1'b1);
          for (int i = 0; i < int'(p) - h; i++) mq.push_back(1'b0);
        end
      end
      mexp = mq.pop_front();
    end
    want = use_model ? mexp : exp;
    checks++;
    if (out !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: out=%b expected %b", name, cyc, out, want);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [7:0] p, input int unsigned n,
                     input logic exp, input string name);
    seg_t s;
    s.rst = r; s.en = e; s.per = p; s.n = n; s.exp = exp; s.name = name;
    tbl.push_back(s);
  endtask

  initial begin
    logic       r_rnd, e_rnd;
    logic [7:0] p_rnd;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    rst        = 1'b1;
    enable     = 1'b0;
    pwm_period = '0;

    // Reset, then idle.
    add(1, 0, 0,  2, 0, "reset");
    add(0, 0, 0,  5, 0, "idle");
    // P=13 for 25 cycles, cut by enable=0.
    add(0, 1, 13, 7, 1, "p13_high1");
    add(0, 1, 13, 6, 0, "p13_low1");
    add(0, 1, 13, 7, 1, "p13_high2");
    add(0, 1, 13, 5, 0, "p13_low2_cut");
    add(0, 0, 13, 3, 0, "p13_off");
    // Enable dropped at phase 3, then a restart from phase 0.
    add(0, 1, 13, 3, 1, "drop_ph0_2");
    add(0, 0, 13, 1, 0, "drop_ph3");
    add(0, 1, 13, 7, 1, "reen_high");
    add(0, 1, 13, 6, 0, "reen_low");
    add(0, 0, 13, 1, 0, "reen_off");
    // Period changes from 13 to 4 at phase 5.
    add(0, 1, 13, 5, 1, "chg_ph0_4");
    add(0, 1, 4,  2, 1, "chg_ph5_6");
    add(0, 1, 4,  6, 0, "chg_low13");
    add(0, 1, 4,  2, 1, "p4_high1");
    add(0, 1, 4,  2, 0, "p4_low1");
    add(0, 1, 4,  2, 1, "p4_high2");
    add(0, 1, 4,  2, 0, "p4_low2");
    add(0, 0, 4,  1, 0, "p4_off");
    // P=0, P=1 and their transitions, each re-sampled on the next cycle.
    add(0, 1, 0,  6, 0, "p0_run");
    add(0, 1, 1,  5, 1, "p0_to_p1");
    add(0, 1, 0,  3, 0, "p1_to_p0");
    add(0, 0, 0,  1, 0, "p0_off");
    // Maximum period.
    add(0, 1, 255, 128, 1, "p255_high");
    add(0, 1, 255, 127, 0, "p255_low");
    add(0, 1, 255, 2,   1, "p255_wrap");
    add(0, 0, 255, 1,   0, "p255_off");

    foreach (tbl[i]) begin
      for (int unsigned k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].rst, tbl[i].en, tbl[i].per, tbl[i].exp, 1'b0, tbl[i].name);
      end
    end

    // Reset asserted mid-high with enable held; resume at phase 0 after it drops.
    for (int k = 0; k < 4; k++) step(0, 1, 13, 1, 1'b0, "rst_pre_high");
    step(1, 1, 13, 0, 1'b0, "rst_mid_high");
    step(1, 1, 13, 0, 1'b0, "rst_hold");
    for (int k = 0; k < 7; k++) step(0, 1, 13, 1, 1'b0, "rst_restart_high");
    step(0, 1, 13, 0, 1'b0, "rst_restart_low");
    step(0, 0, 13, 0, 1'b0, "rst_seq_off");

    // Randomized stimulus checked against the model.
    p_rnd = 8'd5;
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      if (sel < 3)       p_rnd = 8'($urandom_range(0, 255));
      else if (sel < 15) p_rnd = 8'($urandom_range(0, 9));
      e_rnd = ($urandom_range(0, 99) < 96);
      r_rnd = ($urandom_range(0, 299) == 0);
      step(r_rnd, e_rnd, p_rnd, 1'b0, 1'b1, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm.md
PWM -- requirements
Module: pwm

Interface
REQ-001 The block SHALL have parameter CLK_PERIOD, default 20, meaning the clock period in ns (documentation/timing only; no functional effect).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the bit width of pwm_period and the internal counter.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port enable  input  1  level-sensitive run request; 1 runs the PWM, 0 idles it.
REQ-006 The block SHALL have port pwm_period  input  WIDTH  PWM period P in clk cycles, unsigned.
REQ-007 The block SHALL have port out  output  1  registered PWM waveform.

Function
REQ-008 The block SHALL have two states: IDLE (counter 0, out 0) and RUN.
REQ-009 In IDLE, at a clk edge with enable=1 and rst=0, the block SHALL latch P=pwm_period, enter RUN and start the period at phase 0.
REQ-010 High time SHALL be H = P - floor(P/2), i.e. ceil(P/2); low time SHALL be floor(P/2); all arithmetic unsigned in WIDTH bits.
REQ-011 In RUN, out SHALL equal 1 exactly when the current phase k (0..P-1) is below H.
REQ-012 Out SHALL be registered: the edge that enters RUN drives out to the phase-0 value, with no idle cycle before it.
REQ-013 Phase SHALL advance by 1 per clk edge and wrap from P-1 to 0.
REQ-014 On wrap, pwm_period SHALL be re-latched; mid-period changes of pwm_period SHALL NOT affect the current period.
REQ-015 P=0 SHALL hold out at 0 while in RUN, re-sampling pwm_period every cycle.
REQ-016 P=1 SHALL hold out at 1 continuously while in RUN.
REQ-017 P=2^WIDTH-1 SHALL give H=2^(WIDTH-1) high cycles and 2^(WIDTH-1)-1 low cycles, with no counter overflow.
REQ-018 At any clk edge with enable=0, the block SHALL return to IDLE: out goes 0 and the counter clears at that edge, mid-period included.
REQ-019 Re-asserting enable SHALL always restart from phase 0 with a freshly latched P.
REQ-020 Out SHALL be glitch-free, driven directly from a flip-flop.

Reset
REQ-021 When rst=1 at a clk edge, the block SHALL enter IDLE, set out=0, clear the counter and clear the latched period, regardless of enable.
REQ-022 Rst SHALL take priority over enable.
REQ-023 After rst deasserts, the block SHALL start RUN on the first edge with enable=1.
REQ-024 No asynchronous reset path SHALL exist.
REQ-025 Out SHALL be 0 from the first reset edge onward.

Verification
REQ-026 The bench SHALL use CLK_PERIOD=20 and a 20 ns clock, and SHALL change stimulus away from rising edges.
REQ-027 Scenario: rst for 2 cycles, enable=0 for 5 cycles -> out=0 throughout.
REQ-028 Scenario: pwm_period=13, enable=1 for 25 cycles -> out high 7, low 6, high 7, low 5 (cut by enable=0), then 0.
REQ-029 Scenario: pwm_period=13, enable dropped at phase 3 -> out=0 on that edge; re-enable -> 7 high cycles from phase 0.
REQ-030 Scenario: pwm_period changed 13->4 at phase 5 -> current period finishes 7/6, next periods are 2 high / 2 low.
REQ-031 Scenario: pwm_period=0 -> out stays 0; pwm_period=1 -> out stays 1; pwm_period=255 -> 128 high / 127 low.
REQ-032 Scenario: rst=1 asserted mid-high phase with enable=1 -> out=0 on that edge; restart at phase 0 after rst drops.
